// File: rtl/seq_mult_pkg.sv
// Shared definitions for the sequential shift-add multiplier: FSM state
// encoding and the sizing helper for the CALC cycle counter.
package seq_mult_pkg;

    // Binary state encoding; all four codes are legal states, so no
    // unreachable encodings exist.
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_CALC  = 2'd1,
        ST_FIXUP = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    // Counter width large enough to hold the value WIDTH.
    function automatic int cnt_width(input int width);
        return $clog2(width + 1);
    endfunction

endpackage : seq_mult_pkg

// File: rtl/seq_mult_datapath.sv
// Datapath of the sequential multiplier: operand magnitude conversion,
// multiplicand/multiplier/accumulator registers, the accumulate adder and
// the final sign correction that loads the product register.
module seq_mult_datapath #(
    parameter int WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 load,
    input  logic                 calc_en,
    input  logic                 fixup_en,
    input  logic [WIDTH-1:0]     op_a,
    input  logic [WIDTH-1:0]     op_b,
    input  logic                 signed_mode,
    output logic                 mr_done,
    output logic [2*WIDTH-1:0]   product
);

    localparam int PW = 2 * WIDTH;

    // Unsigned magnitude; the most-negative value maps to 2^(WIDTH-1),
    // which still fits in WIDTH unsigned bits.
    function automatic logic [WIDTH-1:0] magnitude(input logic [WIDTH-1:0] x,
                                                   input logic             sgn);
        logic [WIDTH-1:0] r;
        if (sgn && x[WIDTH-1]) begin
            r = (~x) + WIDTH'(1);
        end else begin
            r = x;
        end
        return r;
    endfunction

    logic [PW-1:0]    md_r;
    logic [WIDTH-1:0] mr_r;
    logic [PW-1:0]    acc_r;
    logic             neg_r;
    logic [PW-1:0]    product_r;

    logic [PW-1:0]    acc_sum_s;
    logic [WIDTH-1:0] mr_shift_s;
    logic [PW-1:0]    md_ext_s;
    logic [PW-1:0]    result_s;

    // Shift/add arithmetic for one CALC step and the sign-corrected result.
    always_comb begin
        acc_sum_s  = acc_r + md_r;
        mr_shift_s = {1'b0, mr_r[WIDTH-1:1]};
        md_ext_s   = {{WIDTH{1'b0}}, magnitude(op_a, signed_mode)};
        if (neg_r) begin
            result_s = (~acc_r) + PW'(1);
        end else begin
            result_s = acc_r;
        end
    end

    // The step in progress is the last useful one once the shifted
    // multiplier has no set bits left.
    assign mr_done = (mr_shift_s == {WIDTH{1'b0}});

    // Operand capture at the transfer edge and one shift-add step per CALC cycle.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            md_r  <= {PW{1'b0}};
            mr_r  <= {WIDTH{1'b0}};
            acc_r <= {PW{1'b0}};
            neg_r <= 1'b0;
        end else if (load) begin
            md_r  <= md_ext_s;
            mr_r  <= magnitude(op_b, signed_mode);
            acc_r <= {PW{1'b0}};
            neg_r <= signed_mode & (op_a[WIDTH-1] ^ op_b[WIDTH-1]);
        end else if (calc_en) begin
            if (mr_r[0]) begin
                acc_r <= acc_sum_s;
            end
            md_r <= {md_r[PW-2:0], 1'b0};
            mr_r <= mr_shift_s;
        end
    end

    // Product register: loaded only in FIXUP, otherwise holds its last value.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            product_r <= {PW{1'b0}};
        end else if (fixup_en) begin
            product_r <= result_s;
        end
    end

    assign product = product_r;

endmodule : seq_mult_datapath

// File: rtl/seq_mult_param.sv
// Sequential shift-add multiplier with valid/ready handshakes on both
// sides. Holds the control FSM and the CALC cycle counter; arithmetic
// lives in seq_mult_datapath. WIDTH legal range is 2..32.
module seq_mult_param
    import seq_mult_pkg::*;
#(
    parameter int WIDTH      = 8,
    parameter int EARLY_TERM = 0
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [WIDTH-1:0]     op_a,
    input  logic [WIDTH-1:0]     op_b,
    input  logic                 signed_mode,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [2*WIDTH-1:0]   product,
    output logic                 busy
);

    localparam int               CW       = cnt_width(WIDTH);
    localparam logic [CW-1:0]    CNT_LAST = CW'(WIDTH - 1);

    state_t          state_r;
    state_t          state_s;
    logic [CW-1:0]   cnt_r;
    logic            load_s;
    logic            calc_en_s;
    logic            fixup_en_s;
    logic            calc_last_s;
    logic            mr_done_s;

    seq_mult_datapath #(
        .WIDTH (WIDTH)
    ) u_datapath (
        .clk         (clk),
        .rst         (rst),
        .load        (load_s),
        .calc_en     (calc_en_s),
        .fixup_en    (fixup_en_s),
        .op_a        (op_a),
        .op_b        (op_b),
        .signed_mode (signed_mode),
        .mr_done     (mr_done_s),
        .product     (product)
    );

    // Decide whether the current CALC cycle is the final one.
    always_comb begin
        calc_last_s = 1'b0;
        if (EARLY_TERM != 0) begin
            calc_last_s = mr_done_s;
        end else begin
            calc_last_s = (cnt_r == CNT_LAST);
        end
    end

    // Next-state and datapath strobes.
    always_comb begin
        state_s    = state_r;
        load_s     = 1'b0;
        calc_en_s  = 1'b0;
        fixup_en_s = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (in_valid) begin
                    load_s  = 1'b1;
                    state_s = ST_CALC;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_CALC: begin
                calc_en_s = 1'b1;
                if (calc_last_s) begin
                    state_s = ST_FIXUP;
                end else begin
                    state_s = ST_CALC;
                end
            end
            ST_FIXUP: begin
                fixup_en_s = 1'b1;
                state_s    = ST_DONE;
            end
            ST_DONE: begin
                if (out_ready) begin
                    state_s = ST_IDLE;
                end else begin
                    state_s = ST_DONE;
                end
            end
            default: begin
                state_s = ST_IDLE;
            end
        endcase
    end

    // State register; reset aborts any operation in flight.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // CALC cycle counter: cleared at the transfer, advanced each CALC cycle.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_r <= {CW{1'b0}};
        end else if (load_s) begin
            cnt_r <= {CW{1'b0}};
        end else if (calc_en_s) begin
            cnt_r <= cnt_r + CW'(1);
        end
    end

    // Handshake and status outputs decode straight from the state register,
    // so no input reaches an output combinationally.
    assign in_ready  = (state_r == ST_IDLE);
    assign out_valid = (state_r == ST_DONE);
    assign busy      = (state_r != ST_IDLE);

endmodule : seq_mult_param
